// File: rtl/ez90_pkg.sv
// rtl/ez90_pkg.sv - eZ90 shared uop and issue-queue entry types
package ez90_pkg;

    localparam int EZ90_PREG_W = 7;

    typedef struct packed {
        logic [7:0] opcode;
        logic       rd_valid;
    } ez90_uop_t;

    typedef struct packed {
        ez90_uop_t              uop;
        logic [EZ90_PREG_W-1:0] prs1;
        logic [EZ90_PREG_W-1:0] prs2;
        logic [EZ90_PREG_W-1:0] prd;
    } ez90_uop_rn_t;

    typedef struct packed {
        logic         valid;
        logic         rdy1;
        logic         rdy2;
        ez90_uop_rn_t uop;
    } iq_entry_t;

    function automatic logic tag_hit(input logic en,
                                     input logic [EZ90_PREG_W-1:0] a,
                                     input logic [EZ90_PREG_W-1:0] b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/preg_scoreboard.sv
// rtl/preg_scoreboard.sv - physical-register ready bits with writeback bypass
module preg_scoreboard #(
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              set_valid,
    input  logic [PREG_W-1:0] set_preg,
    input  logic              clr_valid,
    input  logic [PREG_W-1:0] clr_preg,
    input  logic [PREG_W-1:0] rd_preg1,
    input  logic [PREG_W-1:0] rd_preg2,
    output logic              rd_rdy1,
    output logic              rd_rdy2
);

    logic [2**PREG_W-1:0] ready_q;

    assign rd_rdy1 = ready_q[rd_preg1] | (set_valid && (set_preg == rd_preg1));
    assign rd_rdy2 = ready_q[rd_preg2] | (set_valid && (set_preg == rd_preg2));

    // Clear is applied after set so a fresh allocation beats a stale writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= '1;
        end else if (flush) begin
            ready_q <= '1;
        end else begin
            if (set_valid) ready_q[set_preg] <= 1'b1;
            if (clr_valid) ready_q[clr_preg] <= 1'b0;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing age-ordered issue queue with wakeup and oldest-ready select
module issue_queue
    import ez90_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = EZ90_PREG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  ez90_uop_rn_t               in_uop,
    output logic                       in_ready,
    input  logic                       wb_valid,
    input  logic [PREG_W-1:0]          wb_preg,
    output logic                       issue_valid,
    output ez90_uop_rn_t               issue_uop,
    input  logic                       issue_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t         ent_q [DEPTH];
    iq_entry_t         ent_d [DEPTH];
    iq_entry_t         woke  [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     enq_slot;
    logic [IW-1:0]     sel_idx;
    logic              sel_found;
    logic              fire;
    logic              enq;
    logic              src_rdy1;
    logic              src_rdy2;

    preg_scoreboard #(.PREG_W(PREG_W)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .set_valid (wb_valid),
        .set_preg  (wb_preg),
        .clr_valid (enq && in_uop.uop.rd_valid),
        .clr_preg  (in_uop.prd),
        .rd_preg1  (in_uop.prs1),
        .rd_preg2  (in_uop.prs2),
        .rd_rdy1   (src_rdy1),
        .rd_rdy2   (src_rdy2)
    );

    // Find-first from slot 0 (oldest); only registered readiness is used.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign issue_valid = !flush && sel_found;
    assign issue_uop   = issue_valid ? ent_q[sel_idx].uop : '0;
    assign in_ready    = !flush && (count_q < CW'(DEPTH));
    assign count       = count_q;
    assign fire        = issue_valid && issue_ready;
    assign enq         = in_valid && in_ready;
    assign enq_slot    = count_q - CW'(fire);
    assign count_d     = count_q + CW'(enq) - CW'(fire);

    always_comb begin
        int src;
        src = 0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            woke[i].rdy1 = ent_q[i].rdy1 | tag_hit(wb_valid && ent_q[i].valid, ent_q[i].uop.prs1, wb_preg);
            woke[i].rdy2 = ent_q[i].rdy2 | tag_hit(wb_valid && ent_q[i].valid, ent_q[i].uop.prs2, wb_preg);
        end
        for (int i = 0; i < DEPTH; i++) begin
            src = (i + 1 < DEPTH) ? i + 1 : i;
            if (fire && (i >= int'(sel_idx))) begin
                ent_d[i] = (i + 1 < DEPTH) ? woke[src] : '0;
            end else begin
                ent_d[i] = woke[i];
            end
            if (enq && (CW'(i) == enq_slot)) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].rdy1  = src_rdy1;
                ent_d[i].rdy2  = src_rdy2;
                ent_d[i].uop   = in_uop;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (flush) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule
